param_vend_fsm: RTL and testbench
=================================

// Module: param_vend_fsm
// PURPOSE
//  Parametrised vending-machine controller. Accepts half-unit and one-unit coin
//  pulses, sums the credit, and vends when the credit reaches PRICE. Outputs the
//  change due, and refunds the full credit on cancel. Sits behind the coin-input
//  conditioning logic; its outputs drive the dispense and change-return logic.
// PARAMETERS
//  PRICE   5   item price in half-units (5 = 2.5 units); legal range 1..2^CNT_W-3
//  CNT_W   4   width of the credit/change arithmetic; requires PRICE+2 < 2^CNT_W
// PORTS
//  sys_clk        in   1      system clock, rising edge
//  sys_rst_n      in   1      asynchronous active-low reset
//  pi_money_half  in   1      one-cycle pulse: half-unit coin inserted (value 1)
//  pi_money_one   in   1      one-cycle pulse: one-unit coin inserted (value 2)
//  pi_cancel      in   1      one-cycle pulse: abort and return the credit
//  po_cola        out  1      one-cycle pulse: dispense item
//  po_refund      out  1      one-cycle pulse: cancel refund in progress
//  po_change      out  CNT_W  change/refund amount in half-units; valid with po_cola/po_refund, else 0
//  po_credit      out  CNT_W  current accumulated credit (display)
// BEHAVIOUR
//  - Reset: state=IDLE, credit=0, po_cola=0, po_refund=0, po_change=0, po_credit=0.
//    Reset is honoured at any time; a partial credit is discarded with no output pulse.
//  - Coin value per cycle: coin = pi_money_half*1 + pi_money_one*2 (range 0..3).
//    Both coins in the same cycle are both counted. sum = credit + coin, CNT_W bits.
//  - States: IDLE (credit==0) and COLLECT (0<credit<PRICE).
//    Per rising edge, priority order:
//    1. pi_cancel=1: if sum>0, then po_refund=1, po_change=sum, credit=0 -> IDLE.
//       If sum==0, no pulse and stay IDLE. A coin arriving in a cancel cycle is refunded.
//    2. else if sum>=PRICE: po_cola=1, po_change=sum-PRICE, credit=0 -> IDLE.
//    3. else if coin>0: credit=sum -> COLLECT.
//    4. else: hold.
//  - All outputs are registered. A pulse appears the cycle after the sampling edge
//    and lasts exactly 1 cycle. In every other cycle po_cola, po_refund and po_change are 0.
//  - po_cola and po_refund are never high together.
//  - po_credit is updated on the same edge as the credit register. It reads 0 in the
//    cycle a vend or refund pulse is visible.
//  - Back-to-back: a coin in the cycle right after a vend edge starts a new transaction
//    from credit 0, with no dead cycle.
//  - Maximum sum is PRICE+2. No overflow is possible within the legal parameter range.
//  - Inputs are synchronous to sys_clk. Pulses longer than 1 cycle count once per cycle.
// TESTING (PRICE=5, CNT_W=4 unless stated)
//  1. Reset held, random inputs -> all outputs 0. After release, po_credit=0.
//  2. Five single half pulses -> po_credit 1,2,3,4, then po_cola=1 and po_change=0
//     for one cycle; po_credit=0.
//  3. one, one, one -> po_credit 2,4, then po_cola=1, po_change=1.
//  4. half+one together, twice -> po_credit=3, then po_cola=1, po_change=1.
//  5. half, one, then cancel -> po_refund=1, po_change=3, po_cola=0, po_credit=0.
//     Cancel with zero credit -> no pulse.
//  6. Credit 4, then sys_rst_n low mid-cycle -> immediate zero outputs. Then five
//     halves vend normally. Finish with a 10k-cycle random coin/cancel soak checked
//     against a reference model (also run PRICE=7, CNT_W=4).

Source files
------------

// File: rtl/param_vend_fsm.sv
// Vending controller: sums half/one-unit coin pulses, vends at PRICE with change,
// refunds the full credit on cancel. All outputs are registered single-cycle pulses.
module param_vend_fsm #(
  parameter int PRICE = 5,
  parameter int CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pi_money_half,
  input  logic             pi_money_one,
  input  logic             pi_cancel,
  output logic             po_cola,
  output logic             po_refund,
  output logic [CNT_W-1:0] po_change,
  output logic [CNT_W-1:0] po_credit,
  output logic             po_dbg_state
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] W_PRICE = PRICE[CNT_W-1:0];

  state_t           r_state;
  logic [CNT_W-1:0] r_credit;
  logic             r_cola;
  logic             r_refund;
  logic [CNT_W-1:0] r_change;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_credit_nxt;
  logic             w_cola_nxt;
  logic             w_refund_nxt;
  logic [CNT_W-1:0] w_change_nxt;
  logic [CNT_W-1:0] w_coin;
  logic [CNT_W-1:0] w_sum;

  // Coin value is {one, half} read as a 2-bit number: half=1, one=2, both=3.
  assign w_coin = {{(CNT_W-2){1'b0}}, pi_money_one, pi_money_half};
  assign w_sum  = r_credit + w_coin;

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_cola_nxt   = 1'b0;
    w_refund_nxt = 1'b0;
    w_change_nxt = '0;
    if (pi_cancel) begin
      // A coin landing in the cancel cycle is returned along with the credit.
      if (w_sum != '0) begin
        w_refund_nxt = 1'b1;
        w_change_nxt = w_sum;
      end
      w_credit_nxt = '0;
      w_state_nxt  = IDLE;
    end else if (w_sum >= W_PRICE) begin
      w_cola_nxt   = 1'b1;
      w_change_nxt = w_sum - W_PRICE;
      w_credit_nxt = '0;
      w_state_nxt  = IDLE;
    end else if (w_coin != '0) begin
      w_credit_nxt = w_sum;
      w_state_nxt  = COLLECT;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= IDLE;
      r_credit <= '0;
      r_cola   <= 1'b0;
      r_refund <= 1'b0;
      r_change <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_cola   <= w_cola_nxt;
      r_refund <= w_refund_nxt;
      r_change <= w_change_nxt;
    end
  end

  assign po_cola      = r_cola;
  assign po_refund    = r_refund;
  assign po_change    = r_change;
  assign po_credit    = r_credit;
  assign po_dbg_state = r_state;

endmodule

// File: tb/tb_param_vend_fsm.sv
// Bench for param_vend_fsm: directed literal checks plus a per-cycle comparison of
// two instances (PRICE=5 and PRICE=7) against a transaction-level credit model.
module tb_param_vend_fsm;

  localparam int CNT_W = 4;

  // clock / reset
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic pi_money_half = 1'b0;
  logic pi_money_one  = 1'b0;
  logic pi_cancel     = 1'b0;

  logic             cola5, refund5, st5;
  logic [CNT_W-1:0] change5, credit5;
  logic             cola7, refund7, st7;
  logic [CNT_W-1:0] change7, credit7;

  param_vend_fsm #(.PRICE(5), .CNT_W(CNT_W)) dut5 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pi_money_half(pi_money_half), .pi_money_one(pi_money_one), .pi_cancel(pi_cancel),
    .po_cola(cola5), .po_refund(refund5), .po_change(change5), .po_credit(credit5),
    .po_dbg_state(st5)
  );

  param_vend_fsm #(.PRICE(7), .CNT_W(CNT_W)) dut7 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pi_money_half(pi_money_half), .pi_money_one(pi_money_one), .pi_cancel(pi_cancel),
    .po_cola(cola7), .po_refund(refund7), .po_change(change7), .po_credit(credit7),
    .po_dbg_state(st7)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: credit held as an integer, outputs derived from money rules.
  int m_price [2] = '{5, 7};
  int m_credit[2];
  int m_cola  [2];
  int m_ref   [2];
  int m_chg   [2];

  always @(posedge sys_clk or negedge sys_rst_n) begin
    int paid;
    int total;
    for (int k = 0; k < 2; k++) begin
      m_cola[k] = 0;
      m_ref[k]  = 0;
      m_chg[k]  = 0;
      if (!sys_rst_n) begin
        m_credit[k] = 0;
      end else begin
        paid  = (pi_money_half ? 1 : 0) + (pi_money_one ? 2 : 0);
        total = m_credit[k] + paid;
        if (pi_cancel) begin
          if (total > 0) begin
            m_ref[k] = 1;
            m_chg[k] = total;
          end
          m_credit[k] = 0;
        end else if (total >= m_price[k]) begin
          m_cola[k]   = 1;
          m_chg[k]    = total - m_price[k];
          m_credit[k] = 0;
        end else begin
          m_credit[k] = total;
        end
      end
    end
  end

  // scoreboard compare, every falling edge
  always @(negedge sys_clk) begin
    check("cola5",   int'(cola5),   m_cola[0]);
    check("refund5", int'(refund5), m_ref[0]);
    check("change5", int'(change5), m_chg[0]);
    check("credit5", int'(credit5), m_credit[0]);
    check("state5",  int'(st5),     int'(m_credit[0] != 0));
    check("cola7",   int'(cola7),   m_cola[1]);
    check("refund7", int'(refund7), m_ref[1]);
    check("change7", int'(change7), m_chg[1]);
    check("credit7", int'(credit7), m_credit[1]);
    check("state7",  int'(st7),     int'(m_credit[1] != 0));
  end

  // driver: present one cycle of inputs, land just after the sampling edge
  task automatic drive(input logic h, input logic o, input logic c);
    pi_money_half = h;
    pi_money_one  = o;
    pi_cancel     = c;
    @(posedge sys_clk);
    #1;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
  endtask

  task automatic expect5(input string name, input int cola, input int refund,
                         input int change, input int credit);
    check({name, ".cola"},   int'(cola5),   cola);
    check({name, ".refund"}, int'(refund5), refund);
    check({name, ".change"}, int'(change5), change);
    check({name, ".credit"}, int'(credit5), credit);
  endtask

  initial begin
    // 1. reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk);
      #1;
      pi_money_half = 1'($urandom_range(0, 1));
      pi_money_one  = 1'($urandom_range(0, 1));
      pi_cancel     = 1'($urandom_range(0, 1));
      expect5("rst_held", 0, 0, 0, 0);
    end
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    expect5("rst_release", 0, 0, 0, 0);

    // 2. five halves
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      expect5("half_acc", 0, 0, 0, i);
    end
    drive(1'b1, 1'b0, 1'b0);
    expect5("half_vend", 1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0);
    expect5("half_after", 0, 0, 0, 0);

    // 3. one, one, one
    drive(1'b0, 1'b1, 1'b0);
    expect5("one_1", 0, 0, 0, 2);
    drive(1'b0, 1'b1, 1'b0);
    expect5("one_2", 0, 0, 0, 4);
    drive(1'b0, 1'b1, 1'b0);
    expect5("one_vend", 1, 0, 1, 0);

    // back-to-back: 4. half+one twice, starting right after the vend
    drive(1'b1, 1'b1, 1'b0);
    expect5("both_1", 0, 0, 0, 3);
    drive(1'b1, 1'b1, 1'b0);
    expect5("both_vend", 1, 0, 1, 0);

    // 5. half, one, cancel; then cancel with nothing inserted
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    expect5("pre_cancel", 0, 0, 0, 3);
    drive(1'b0, 1'b0, 1'b1);
    expect5("cancel", 0, 1, 3, 0);
    drive(1'b0, 1'b0, 1'b1);
    expect5("cancel_zero", 0, 0, 0, 0);
    // coin in the cancel cycle is refunded too
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    expect5("cancel_coin", 0, 1, 3, 0);

    // 6. credit 4 then asynchronous reset mid-cycle
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    expect5("pre_reset", 0, 0, 0, 4);
    #2;
    sys_rst_n = 1'b0;
    #1;
    expect5("async_reset", 0, 0, 0, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 1'b0);
    expect5("post_rst_acc", 0, 0, 0, 4);
    drive(1'b1, 1'b0, 1'b0);
    expect5("post_rst_vend", 1, 0, 0, 0);

    // random soak, both price instances checked by the scoreboard
    for (int i = 0; i < 10000; i++) begin
      pi_money_half = ($urandom_range(0, 2) == 0);
      pi_money_one  = ($urandom_range(0, 2) == 0);
      pi_cancel     = ($urandom_range(0, 9) == 0);
      @(posedge sys_clk);
      #1;
      check("exclusive5", int'(cola5 & refund5), 0);
      check("exclusive7", int'(cola7 & refund7), 0);
    end
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
